backend_access_scheduler: RTL and testbench

//  Sits in front of the ORAM backend command port: shares it between two frontend requesters (port 0 = PosMap/PLB, port 1 = data/LLC).

---
 rtl/backend_access_scheduler.sv | 105 ++++++++++
 tb/tb_backend_access_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/backend_access_scheduler.sv
// backend_access_scheduler: shares the ORAM backend command port between two requesters at a fixed access rate,
// filling idle slots with dummy path accesses and routing completions back to the owning requester.
module backend_access_scheduler #(
   parameter int ORAMU = 32,
   parameter int ORAML = 10,
   parameter int BECMDWidth = 2,
   parameter int AccessRate = 64,
   parameter int RateWidth = 16
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [BECMDWidth-1:0] ReqCommand0,
   input  logic [ORAMU-1:0]      ReqPAddr0,
   input  logic [ORAML-1:0]      ReqCurLeaf0,
   input  logic [ORAML-1:0]      ReqRemapLeaf0,
   input  logic                  ReqValid0,
   output logic                  ReqReady0,
   output logic                  ReqDone0,
   input  logic [BECMDWidth-1:0] ReqCommand1,
   input  logic [ORAMU-1:0]      ReqPAddr1,
   input  logic [ORAML-1:0]      ReqCurLeaf1,
   input  logic [ORAML-1:0]      ReqRemapLeaf1,
   input  logic                  ReqValid1,
   output logic                  ReqReady1,
   output logic                  ReqDone1,
   output logic [BECMDWidth-1:0] Command,
   output logic [ORAMU-1:0]      PAddr,
   output logic [ORAML-1:0]      CurrentLeaf,
   output logic [ORAML-1:0]      RemappedLeaf,
   output logic                  CommandRequest,
   output logic                  DummyRequest,
   input  logic                  CommandDone,
   input  logic                  PathComplete,
   output logic                  SlotOverrun
);
   localparam int EntryW = BECMDWidth + ORAMU + 2 * ORAML;
   localparam logic [BECMDWidth-1:0] BECMDRead = BECMDWidth'(2);
   localparam logic [EntryW-1:0] DummyEntry = {BECMDRead, {(EntryW - BECMDWidth){1'b0}}};
   localparam logic [RateWidth-1:0] SlotReload = (AccessRate == 0) ? '0 : RateWidth'(AccessRate - 1);

   typedef enum logic [1:0] {ST_Idle, ST_Real, ST_Dummy} state_t;

   state_t state;
   logic [1:0] slotFull, reqValid;
   logic [EntryW-1:0] reqData [2];
   logic [EntryW-1:0] slotData [2];
   logic [EntryW-1:0] outData;
   logic [RateWidth-1:0] slotCtr;
   logic rrPtr, owner, winner, slotFire, issueReal, issueDummy, realDone, dummyDone;

   assign reqValid = {ReqValid1, ReqValid0};
   assign reqData[0] = {ReqCommand0, ReqPAddr0, ReqCurLeaf0, ReqRemapLeaf0};
   assign reqData[1] = {ReqCommand1, ReqPAddr1, ReqCurLeaf1, ReqRemapLeaf1};
   assign {Command, PAddr, CurrentLeaf, RemappedLeaf} = outData;

   assign slotFire = slotCtr == '0;
   assign winner = slotFull[rrPtr] ? rrPtr : ~rrPtr;
   assign issueReal = state == ST_Idle && (AccessRate == 0 || slotFire) && |slotFull;
   assign issueDummy = state == ST_Idle && AccessRate != 0 && slotFire && !(|slotFull);
   assign realDone = state == ST_Real && CommandDone;
   assign dummyDone = state == ST_Dummy && PathComplete;

   assign ReqReady0 = ~slotFull[0];
   assign ReqReady1 = ~slotFull[1];
   assign ReqDone0 = realDone && !owner;
   assign ReqDone1 = realDone && owner;
   assign CommandRequest = state != ST_Idle;
   assign DummyRequest = state == ST_Dummy;

   // A slot is never captured and issued on the same edge: issue needs it full, capture needs it empty.
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         slotFull <= '0;
         slotData <= '{default: '0};
      end else
         for (int n = 0; n < 2; n++)
            if (issueReal && winner == n[0]) slotFull[n] <= 1'b0;
            else if (reqValid[n] && !slotFull[n]) begin
               slotFull[n] <= 1'b1;
               slotData[n] <= reqData[n];
            end

   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         state <= ST_Idle;
         rrPtr <= 1'b0;
         owner <= 1'b0;
         outData <= '0;
         slotCtr <= SlotReload;
         SlotOverrun <= 1'b0;
      end else begin
         SlotOverrun <= state != ST_Idle && !realDone && !dummyDone && slotCtr == RateWidth'(1);
         if (issueReal || issueDummy) slotCtr <= SlotReload;
         else if (!slotFire) slotCtr <= slotCtr - 1'b1;
         if (issueReal) begin
            state <= ST_Real;
            owner <= winner;
            rrPtr <= ~winner;
            outData <= slotData[winner];
         end else if (issueDummy) begin
            state <= ST_Dummy;
            outData <= DummyEntry;
         end else if (realDone || dummyDone) state <= ST_Idle;
      end
endmodule

// File: tb/tb_backend_access_scheduler.sv
// tb_backend_access_scheduler: directed checks of the scheduler at AccessRate 0, 16 and 8.
// Instance 0 uses AccessRate=0, instance 1 AccessRate=16, instance 2 AccessRate=8; all share the inputs.
module tb_backend_access_scheduler;
   logic Clock = 1'b0, Reset = 1'b0;
   logic [1:0] reqCmd0, reqCmd1;
   logic [31:0] reqAddr0, reqAddr1;
   logic [9:0] reqCur0, reqCur1, reqRemap0, reqRemap1;
   logic reqValid0, reqValid1, commandDone, pathComplete;
   logic ready0 [3], ready1 [3], done0 [3], done1 [3], cmdReq [3], dummyReq [3], overrun [3];
   logic [1:0] cmd [3];
   logic [31:0] paddr [3];
   logic [9:0] curLeaf [3], remapLeaf [3];
   int total = 0, bad = 0;

   always #5 Clock = ~Clock;

   for (genvar g = 0; g < 3; g++) begin : gDut
      backend_access_scheduler #(.AccessRate(g == 0 ? 0 : (g == 1 ? 16 : 8))) dut (
         .Clock(Clock), .Reset(Reset),
         .ReqCommand0(reqCmd0), .ReqPAddr0(reqAddr0), .ReqCurLeaf0(reqCur0), .ReqRemapLeaf0(reqRemap0),
         .ReqValid0(reqValid0), .ReqReady0(ready0[g]), .ReqDone0(done0[g]),
         .ReqCommand1(reqCmd1), .ReqPAddr1(reqAddr1), .ReqCurLeaf1(reqCur1), .ReqRemapLeaf1(reqRemap1),
         .ReqValid1(reqValid1), .ReqReady1(ready1[g]), .ReqDone1(done1[g]),
         .Command(cmd[g]), .PAddr(paddr[g]), .CurrentLeaf(curLeaf[g]), .RemappedLeaf(remapLeaf[g]),
         .CommandRequest(cmdReq[g]), .DummyRequest(dummyReq[g]),
         .CommandDone(commandDone), .PathComplete(pathComplete), .SlotOverrun(overrun[g])
      );
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Leaves the bench 1 time unit after the edge that starts post-reset cycle 0.
   task automatic doReset();
      Reset = 1'b0;
      {reqValid0, reqValid1, commandDone, pathComplete} = '0;
      {reqCmd0, reqCmd1, reqAddr0, reqAddr1} = '0;
      {reqCur0, reqCur1, reqRemap0, reqRemap1} = '0;
      step();
      step();
      Reset = 1'b1;
   endtask

   task automatic test_reset();
      doReset();
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({ready0[i], ready1[i], done0[i], done1[i], cmdReq[i], dummyReq[i], overrun[i]} !== 7'b1100000) begin
            bad++;
            $display("FAIL reset_ctl[%0d]: got %b want 1100000", i,
               {ready0[i], ready1[i], done0[i], done1[i], cmdReq[i], dummyReq[i], overrun[i]});
         end
         total++;
         if ({cmd[i], paddr[i], curLeaf[i], remapLeaf[i]} !== 54'd0) begin
            bad++;
            $display("FAIL reset_data[%0d]: got %h want 0", i, {cmd[i], paddr[i], curLeaf[i], remapLeaf[i]});
         end
      end
   endtask

   task automatic test_rate0();
      doReset();
      reqValid0 = 1'b1; reqCmd0 = 2'd1; reqAddr0 = 32'h1234; reqCur0 = 10'h3; reqRemap0 = 10'h5;
      step();
      reqValid0 = 1'b0;
      total++;
      if ({ready0[0], cmdReq[0]} !== 2'b00) begin
         bad++; $display("FAIL rate0_capture: ready/req got %b want 00", {ready0[0], cmdReq[0]});
      end
      step();
      total++;
      if ({cmdReq[0], dummyReq[0], ready0[0]} !== 3'b101) begin
         bad++; $display("FAIL rate0_issue: req/dummy/ready got %b want 101", {cmdReq[0], dummyReq[0], ready0[0]});
      end
      total++;
      if ({cmd[0], paddr[0], curLeaf[0], remapLeaf[0]} !== {2'd1, 32'h1234, 10'h3, 10'h5}) begin
         bad++; $display("FAIL rate0_fields: got %h/%h/%h/%h want 1/1234/3/5", cmd[0], paddr[0], curLeaf[0], remapLeaf[0]);
      end
      step();
      step();
      total++;
      if ({cmdReq[0], done0[0]} !== 2'b10) begin
         bad++; $display("FAIL rate0_hold: req/done got %b want 10", {cmdReq[0], done0[0]});
      end
      commandDone = 1'b1;
      #1;
      total++;
      if ({done0[0], done1[0]} !== 2'b10) begin
         bad++; $display("FAIL rate0_done: done0/1 got %b want 10", {done0[0], done1[0]});
      end
      step();
      commandDone = 1'b0;
      total++;
      if ({done0[0], cmdReq[0]} !== 2'b00) begin
         bad++; $display("FAIL rate0_done_width: done/req got %b want 00", {done0[0], cmdReq[0]});
      end
   endtask

   task automatic test_dummy();
      logic expDummy;
      doReset();
      for (int c = 0; c <= 40; c++) begin
         expDummy = (c >= 16 && c <= 20) || c >= 32;
         total++;
         if ({cmdReq[1], dummyReq[1], done0[1], done1[1]} !== {expDummy, expDummy, 2'b00}) begin
            bad++; $display("FAIL dummy_cycle%0d: req/dummy/done0/done1 got %b want %b", c,
               {cmdReq[1], dummyReq[1], done0[1], done1[1]}, {expDummy, expDummy, 2'b00});
         end
         if (c == 16) begin
            total++;
            if ({cmd[1], paddr[1], curLeaf[1], remapLeaf[1]} !== {2'd2, 52'd0}) begin
               bad++; $display("FAIL dummy_fields: got %h want read with zero address", {cmd[1], paddr[1], curLeaf[1], remapLeaf[1]});
            end
         end
         pathComplete = c == 20;
         step();
      end
      pathComplete = 1'b0;
   endtask

   task automatic test_round_robin();
      int k;
      doReset();
      reqValid0 = 1'b1; reqValid1 = 1'b1; reqAddr0 = 32'hA0; reqAddr1 = 32'hB0;
      for (int a = 0; a < 4; a++) begin
         k = 0;
         while (!cmdReq[0] && k < 20) begin
            step();
            k++;
         end
         total++;
         if (cmdReq[0] !== 1'b1) begin
            bad++; $display("FAIL rr_timeout%0d: req got %b want 1", a, cmdReq[0]);
         end
         total++;
         if (paddr[0] !== (a % 2 == 1 ? 32'hB0 : 32'hA0)) begin
            bad++; $display("FAIL rr_grant%0d: paddr got %h want %h", a, paddr[0], (a % 2 == 1 ? 32'hB0 : 32'hA0));
         end
         total++;
         if ((a % 2 == 1 ? ready0[0] : ready1[0]) !== 1'b0) begin
            bad++; $display("FAIL rr_wait_ready%0d: got 1 want 0", a);
         end
         step();
         commandDone = 1'b1;
         #1;
         total++;
         if ({done0[0], done1[0]} !== (a % 2 == 1 ? 2'b01 : 2'b10)) begin
            bad++; $display("FAIL rr_done%0d: done0/1 got %b want %b", a, {done0[0], done1[0]}, (a % 2 == 1 ? 2'b01 : 2'b10));
         end
         step();
         commandDone = 1'b0;
      end
      reqValid0 = 1'b0; reqValid1 = 1'b0;
   endtask

   task automatic test_overrun();
      int k, hits;
      doReset();
      reqValid0 = 1'b1; reqAddr0 = 32'h800;
      step();
      reqValid0 = 1'b0;
      k = 1;
      while (!cmdReq[2] && k < 30) begin
         step();
         k++;
      end
      total++;
      if (k !== 8 || cmdReq[2] !== 1'b1) begin
         bad++; $display("FAIL ovr_first_issue: issued at cycle %0d req %b want cycle 8 req 1", k, cmdReq[2]);
      end
      reqValid1 = 1'b1; reqAddr1 = 32'h900;
      step();
      reqValid1 = 1'b0;
      hits = 0;
      for (int i = 0; i < 19; i++) begin
         hits += int'(overrun[2]);
         step();
      end
      total++;
      if (hits !== 1) begin
         bad++; $display("FAIL ovr_pulses: got %0d want 1", hits);
      end
      total++;
      if ({cmdReq[2], ready1[2]} !== 2'b10) begin
         bad++; $display("FAIL ovr_busy: req/ready1 got %b want 10", {cmdReq[2], ready1[2]});
      end
      commandDone = 1'b1;
      #1;
      total++;
      if (done0[2] !== 1'b1) begin
         bad++; $display("FAIL ovr_done: done0 got %b want 1", done0[2]);
      end
      step();
      commandDone = 1'b0;
      total++;
      if ({cmdReq[2], ready1[2]} !== 2'b00) begin
         bad++; $display("FAIL ovr_idle: req/ready1 got %b want 00", {cmdReq[2], ready1[2]});
      end
      step();
      total++;
      if ({cmdReq[2], ready1[2], paddr[2]} !== {2'b11, 32'h900}) begin
         bad++; $display("FAIL ovr_pending_issue: req/ready1/paddr got %b/%b/%h want 1/1/900", cmdReq[2], ready1[2], paddr[2]);
      end
   endtask

   task automatic test_reset_mid();
      int hits;
      doReset();
      reqValid0 = 1'b1; reqAddr0 = 32'h55;
      step();
      reqValid0 = 1'b0;
      step();
      total++;
      if (cmdReq[0] !== 1'b1) begin
         bad++; $display("FAIL rstmid_setup: req got %b want 1", cmdReq[0]);
      end
      Reset = 1'b0;
      commandDone = 1'b1;
      #1;
      total++;
      if ({cmdReq[0], done0[0], done1[0]} !== 3'b000) begin
         bad++; $display("FAIL rstmid_abort: req/done0/done1 got %b want 000", {cmdReq[0], done0[0], done1[0]});
      end
      step();
      commandDone = 1'b0;
      step();
      Reset = 1'b1;
      hits = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         hits += int'(done0[0]) + int'(done1[0]) + int'(cmdReq[0]);
      end
      total++;
      if ({hits == 0, ready0[0], ready1[0]} !== 3'b111) begin
         bad++; $display("FAIL rstmid_after: activity %0d ready0/1 %b want 0 and 11", hits, {ready0[0], ready1[0]});
      end
   endtask

   task automatic test_done_capture();
      int k;
      doReset();
      reqValid0 = 1'b1; reqAddr0 = 32'h10;
      step();
      reqValid0 = 1'b0;
      k = 0;
      while (!cmdReq[2] && k < 30) begin
         step();
         k++;
      end
      step();
      commandDone = 1'b1; reqValid1 = 1'b1; reqAddr1 = 32'h20;
      #1;
      total++;
      if ({done0[2], ready1[2]} !== 2'b11) begin
         bad++; $display("FAIL dc_same_cycle: done0/ready1 got %b want 11", {done0[2], ready1[2]});
      end
      step();
      commandDone = 1'b0; reqValid1 = 1'b0;
      total++;
      if ({ready1[2], cmdReq[2]} !== 2'b00) begin
         bad++; $display("FAIL dc_captured: ready1/req got %b want 00", {ready1[2], cmdReq[2]});
      end
      k = 0;
      while (!cmdReq[2] && k < 30) begin
         step();
         k++;
      end
      total++;
      if (k !== 6 || paddr[2] !== 32'h20) begin
         bad++; $display("FAIL dc_next_fire: issued after %0d cycles paddr %h want 6 and 20", k, paddr[2]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_rate0();
      test_dummy();
      test_round_robin();
      test_overrun();
      test_reset_mid();
      test_done_capture();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
